// File: rtl/rc4_key_dispatch_pkg.sv
// rc4_pkg: shared types and defaults for the RC4 key-search dispatcher.
//   state_e           : dispatcher FSM states
//   key_t             : key word at the default key width
//   DEFAULT_KEY_BITS  : default key width in bits
//   DEFAULT_CHUNK_LOG : default log2 of keys per dispatched chunk
package rc4_pkg;

  localparam int unsigned DEFAULT_KEY_BITS  = 24;
  localparam int unsigned DEFAULT_CHUNK_LOG = 10;

  typedef logic [DEFAULT_KEY_BITS-1:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rc4_key_dispatch_if.sv
// rc4_key_dispatch_if: control, core handshake and status bundle of the
// key dispatcher.
//   start/abort                 : search control pulses
//   core_req/core_done/core_hit : per-core request level, done pulse, hit flag
//   core_hit_key                : per-core winning key, qualified by core_done
//   core_grant/core_base/core_end : chunk assignment to one core
//   kill/busy/finished/found/found_key : status
// Modport slave is the dispatcher; master is the controller/core side.
interface rc4_key_dispatch_if
  import rc4_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned KEY_BITS  = DEFAULT_KEY_BITS
);
  logic                               start;
  logic                               abort;
  logic [NUM_CORES-1:0]               core_req;
  logic [NUM_CORES-1:0]               core_done;
  logic [NUM_CORES-1:0]               core_hit;
  logic [NUM_CORES-1:0][KEY_BITS-1:0] core_hit_key;
  logic [NUM_CORES-1:0]               core_grant;
  logic [KEY_BITS-1:0]                core_base;
  logic [KEY_BITS-1:0]                core_end;
  logic                               kill;
  logic                               busy;
  logic                               finished;
  logic                               found;
  logic [KEY_BITS-1:0]                found_key;

  modport master (
    output start, abort, core_req, core_done, core_hit, core_hit_key,
    input  core_grant, core_base, core_end, kill, busy, finished, found, found_key
  );

  modport slave (
    input  start, abort, core_req, core_done, core_hit, core_hit_key,
    output core_grant, core_base, core_end, kill, busy, finished, found, found_key
  );
endinterface

// File: rtl/rc4_key_dispatch_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a one-hot grant.
//   clk_i, rst_ni : clock, async active-low reset
//   req_i         : request vector
//   adv_i         : grant is taken; pointer moves past the winner
//   gnt_o         : one-hot grant (zero when no request)
//   valid_o       : some request is granted
module rr_arbiter #(
  parameter int unsigned NUM_CORES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_CORES-1:0] req_i,
  input  logic                 adv_i,
  output logic [NUM_CORES-1:0] gnt_o,
  output logic                 valid_o
);
  localparam int unsigned PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  // ptr_q is the highest-priority core: one past the last core granted.
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_idx, idx;
  logic [PW:0]   sum;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    win_idx = '0;
    idx     = '0;
    sum     = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_CORES)) sum = sum - (PW+1)'(NUM_CORES);
      idx = sum[PW-1:0];
      if (!valid_o && req_i[idx]) begin
        valid_o      = 1'b1;
        gnt_o[idx]   = 1'b1;
        win_idx      = idx;
      end
    end
    ptr_d = ptr_q;
    if (adv_i && valid_o)
      ptr_d = (win_idx == PW'(NUM_CORES-1)) ? '0 : win_idx + PW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/rc4_key_dispatch.sv
// rc4_key_dispatch: splits [KEY_LOWER, KEY_UPPER] into 2^CHUNK_LOG-key chunks
// and hands them round-robin to idle decryption cores; the first reported hit
// wins and kills the remaining cores.
//   clk   : system clock (rising edge)
//   reset : asynchronous active-low reset, release synchronised internally
//   bus   : rc4_key_dispatch_if.slave (control, core handshake, status)
module rc4_key_dispatch
  import rc4_pkg::*;
#(
  parameter int unsigned         NUM_CORES = 4,
  parameter int unsigned         KEY_BITS  = DEFAULT_KEY_BITS,
  parameter int unsigned         CHUNK_LOG = DEFAULT_CHUNK_LOG,
  parameter logic [KEY_BITS-1:0] KEY_LOWER = '0,
  parameter logic [KEY_BITS-1:0] KEY_UPPER = '1
) (
  input logic             clk,
  input logic             reset,
  rc4_key_dispatch_if.slave bus
);
  localparam int unsigned      KW         = KEY_BITS + 1;
  localparam logic [KEY_BITS:0] CHUNK_SPAN = KW'((64'd1 << CHUNK_LOG) - 64'd1);
  localparam logic [KEY_BITS:0] UPPER_W    = {1'b0, KEY_UPPER};

  logic [1:0] rst_sync_q;
  logic       rst_n;

  state_e               state_q, state_d;
  logic [KEY_BITS:0]    next_base_q, next_base_d;
  logic [NUM_CORES-1:0] outstanding_q, outstanding_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [KEY_BITS-1:0]  base_q, base_d, end_q, end_d, found_key_q, found_key_d;
  logic                 kill_q, kill_d, busy_q, busy_d;
  logic                 finished_q, finished_d, found_q, found_d;

  logic [NUM_CORES-1:0] eligible, arb_gnt, hit_mask;
  logic                 arb_valid, grant_fire, hit_seen, exhausted;
  logic [KEY_BITS-1:0]  hit_key;
  logic [KEY_BITS:0]    span_end, chunk_end;

  // Assert asynchronously, release on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // A core finishing this cycle is only eligible from the next cycle on.
  assign eligible   = bus.core_req & ~outstanding_q & ~bus.core_done;
  assign grant_fire = (state_q == ST_DISPATCH) && arb_valid && !hit_seen && !bus.abort;

  rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (eligible),
    .adv_i   (grant_fire),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  // Extra top bit keeps next_base from wrapping past the last key.
  assign span_end  = next_base_q + CHUNK_SPAN;
  assign exhausted = (span_end >= UPPER_W);
  assign chunk_end = exhausted ? UPPER_W : span_end;

  assign hit_mask = bus.core_done & bus.core_hit;

  always_comb begin
    hit_key  = '0;
    hit_seen = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (hit_mask[i] && !hit_seen) begin
        hit_key  = bus.core_hit_key[i];
        hit_seen = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    next_base_d   = next_base_q;
    outstanding_d = outstanding_q & ~bus.core_done;
    grant_d       = '0;
    base_d        = base_q;
    end_d         = end_q;
    kill_d        = kill_q;
    found_d       = found_q;
    found_key_d   = found_key_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d       = ST_DISPATCH;
          next_base_d   = {1'b0, KEY_LOWER};
          outstanding_d = '0;
          found_d       = 1'b0;
          kill_d        = 1'b0;
        end
      end
      ST_DISPATCH: begin
        if (hit_seen) begin
          found_d     = 1'b1;
          found_key_d = hit_key;
          kill_d      = 1'b1;
          state_d     = ST_DRAIN;
        end else if (bus.abort) begin
          kill_d  = 1'b1;
          state_d = ST_DRAIN;
        end else if (grant_fire) begin
          grant_d       = arb_gnt;
          outstanding_d = outstanding_d | arb_gnt;
          base_d        = next_base_q[KEY_BITS-1:0];
          end_d         = chunk_end[KEY_BITS-1:0];
          next_base_d   = chunk_end + KW'(1);
          if (exhausted) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!kill_q && hit_seen) begin
          found_d     = 1'b1;
          found_key_d = hit_key;
          kill_d      = 1'b1;
        end else if (bus.abort) begin
          kill_d = 1'b1;
        end
        if (~|outstanding_d) begin
          state_d = ST_DONE;
          kill_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d     = (state_d == ST_DISPATCH) || (state_d == ST_DRAIN);
    finished_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      next_base_q   <= '0;
      outstanding_q <= '0;
      grant_q       <= '0;
      base_q        <= '0;
      end_q         <= '0;
      kill_q        <= 1'b0;
      busy_q        <= 1'b0;
      finished_q    <= 1'b0;
      found_q       <= 1'b0;
      found_key_q   <= '0;
    end else begin
      state_q       <= state_d;
      next_base_q   <= next_base_d;
      outstanding_q <= outstanding_d;
      grant_q       <= grant_d;
      base_q        <= base_d;
      end_q         <= end_d;
      kill_q        <= kill_d;
      busy_q        <= busy_d;
      finished_q    <= finished_d;
      found_q       <= found_d;
      found_key_q   <= found_key_d;
    end
  end

  assign bus.core_grant = grant_q;
  assign bus.core_base  = base_q;
  assign bus.core_end   = end_q;
  assign bus.kill       = kill_q;
  assign bus.busy       = busy_q;
  assign bus.finished   = finished_q;
  assign bus.found      = found_q;
  assign bus.found_key  = found_key_q;
endmodule

// File: tb/tb_rc4_key_dispatch.sv
// tb_rc4_key_dispatch: directed bench for rc4_key_dispatch.
// u_dut0: 4 cores, chunks of 4, keys 0..15 (main scenarios)
// u_dut1: keys 0..9 (short final chunk)
// u_dut2: default chunk size, keys fff800..ffffff (no wrap at top of space)
module tb_rc4_key_dispatch;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rc4_key_dispatch_if #(.NUM_CORES(4), .KEY_BITS(24)) bus0 ();
  rc4_key_dispatch_if #(.NUM_CORES(4), .KEY_BITS(24)) bus1 ();
  rc4_key_dispatch_if #(.NUM_CORES(4), .KEY_BITS(24)) bus2 ();

  rc4_key_dispatch #(.NUM_CORES(4), .KEY_BITS(24), .CHUNK_LOG(2),
                     .KEY_LOWER(24'd0), .KEY_UPPER(24'd15))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  rc4_key_dispatch #(.NUM_CORES(4), .KEY_BITS(24), .CHUNK_LOG(2),
                     .KEY_LOWER(24'd0), .KEY_UPPER(24'd9))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  rc4_key_dispatch #(.NUM_CORES(4), .KEY_BITS(24), .CHUNK_LOG(10),
                     .KEY_LOWER(24'hfff800), .KEY_UPPER(24'hffffff))
    u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned kill_cycles = 0;

  always @(posedge clk) if (bus0.kill) kill_cycles <= kill_cycles + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_chunk(input string tag, input logic [3:0] gnt, input logic [3:0] eg,
                           input logic [23:0] b, input logic [23:0] eb,
                           input logic [23:0] e, input logic [23:0] ee);
    check({tag, ".gnt"},  32'(gnt), 32'(eg));
    check({tag, ".base"}, 32'(b),   32'(eb));
    check({tag, ".end"},  32'(e),   32'(ee));
  endtask

  initial begin
    bus0.start = 0; bus0.abort = 0; bus0.core_req = '0; bus0.core_done = '0;
    bus0.core_hit = '0; bus0.core_hit_key = '0;
    bus1.start = 0; bus1.abort = 0; bus1.core_req = '0; bus1.core_done = '0;
    bus1.core_hit = '0; bus1.core_hit_key = '0;
    bus2.start = 0; bus2.abort = 0; bus2.core_req = '0; bus2.core_done = '0;
    bus2.core_hit = '0; bus2.core_hit_key = '0;
    tick(); tick();

    check("rst.grant",    32'(bus0.core_grant), 0);
    check("rst.busy",     32'(bus0.busy), 0);
    check("rst.finished", 32'(bus0.finished), 0);
    check("rst.found",    32'(bus0.found), 0);
    check("rst.kill",     32'(bus0.kill), 0);
    check("rst.fkey",     32'(bus0.found_key), 0);
    check("rst.base",     32'(bus0.core_base), 0);
    check("rst.end",      32'(bus0.core_end), 0);
    reset = 1'b1;
    repeat (4) tick();
    check("idle.busy", 32'(bus0.busy), 0);

    // Full sweep, all cores requesting, no hits.
    bus0.core_req = 4'hf; bus1.core_req = 4'hf; bus2.core_req = 4'hf;
    bus0.start = 1; bus1.start = 1; bus2.start = 1;
    tick();
    bus0.start = 0; bus1.start = 0; bus2.start = 0;
    check("A.busy", 32'(bus0.busy), 1);
    check("A.nogrant", 32'(bus0.core_grant), 0);
    tick();
    chk_chunk("A.c0", bus0.core_grant, 4'b0001, bus0.core_base, 24'd0, bus0.core_end, 24'd3);
    chk_chunk("U9.c0", bus1.core_grant, 4'b0001, bus1.core_base, 24'd0, bus1.core_end, 24'd3);
    chk_chunk("TOP.c0", bus2.core_grant, 4'b0001, bus2.core_base, 24'hfff800, bus2.core_end, 24'hfffbff);
    tick();
    chk_chunk("A.c1", bus0.core_grant, 4'b0010, bus0.core_base, 24'd4, bus0.core_end, 24'd7);
    chk_chunk("U9.c1", bus1.core_grant, 4'b0010, bus1.core_base, 24'd4, bus1.core_end, 24'd7);
    chk_chunk("TOP.c1", bus2.core_grant, 4'b0010, bus2.core_base, 24'hfffc00, bus2.core_end, 24'hffffff);
    tick();
    chk_chunk("A.c2", bus0.core_grant, 4'b0100, bus0.core_base, 24'd8, bus0.core_end, 24'd11);
    chk_chunk("U9.c2", bus1.core_grant, 4'b0100, bus1.core_base, 24'd8, bus1.core_end, 24'd9);
    check("TOP.nogrant2", 32'(bus2.core_grant), 0);
    tick();
    chk_chunk("A.c3", bus0.core_grant, 4'b1000, bus0.core_base, 24'd12, bus0.core_end, 24'd15);
    check("U9.nogrant3", 32'(bus1.core_grant), 0);
    check("TOP.nogrant3", 32'(bus2.core_grant), 0);
    tick();
    check("A.drain.grant", 32'(bus0.core_grant), 0);
    check("A.drain.busy",  32'(bus0.busy), 1);
    check("U9.drain.grant", 32'(bus1.core_grant), 0);
    check("TOP.drain.grant", 32'(bus2.core_grant), 0);
    bus0.core_req = '0; bus0.core_done = 4'hf;
    tick();
    bus0.core_done = '0;
    check("A.finished", 32'(bus0.finished), 1);
    check("A.busy0",    32'(bus0.busy), 0);
    check("A.found",    32'(bus0.found), 0);
    check("A.kill",     32'(bus0.kill), 0);
    check("A.kill_cycles", kill_cycles, 0);

    // Simultaneous hits from cores 1 and 3: lowest index wins.
    bus0.core_req = 4'hf; bus0.start = 1;
    tick();
    bus0.start = 0;
    repeat (4) tick();
    check("B.lastgrant", 32'(bus0.core_grant), 32'(4'b1000));
    bus0.core_req = '0;
    bus0.core_done = 4'b1010; bus0.core_hit = 4'b1010;
    bus0.core_hit_key[1] = 24'd5; bus0.core_hit_key[3] = 24'd13;
    tick();
    bus0.core_done = '0; bus0.core_hit = '0;
    check("B.found", 32'(bus0.found), 1);
    check("B.fkey",  32'(bus0.found_key), 5);
    check("B.kill",  32'(bus0.kill), 1);
    check("B.busy",  32'(bus0.busy), 1);
    bus0.core_done = 4'b0001; bus0.core_hit = 4'b0001; bus0.core_hit_key[0] = 24'd7;
    tick();
    bus0.core_done = '0; bus0.core_hit = '0;
    check("B.late.fkey", 32'(bus0.found_key), 5);
    check("B.late.kill", 32'(bus0.kill), 1);
    bus0.core_done = 4'b0100;
    tick();
    bus0.core_done = '0;
    check("B.done.kill", 32'(bus0.kill), 0);
    check("B.done.fin",  32'(bus0.finished), 1);
    check("B.done.found", 32'(bus0.found), 1);
    check("B.done.fkey", 32'(bus0.found_key), 5);

    // Abort two cycles after start.
    bus0.core_req = 4'hf; bus0.start = 1;
    tick();
    bus0.start = 0;
    check("C.found_cleared", 32'(bus0.found), 0);
    check("C.fin_cleared",   32'(bus0.finished), 0);
    tick();
    check("C.grant0", 32'(bus0.core_grant), 32'(4'b0001));
    bus0.abort = 1;
    tick();
    bus0.abort = 0;
    check("C.abort.grant", 32'(bus0.core_grant), 0);
    check("C.abort.kill",  32'(bus0.kill), 1);
    tick();
    check("C.hold.grant", 32'(bus0.core_grant), 0);
    check("C.hold.kill",  32'(bus0.kill), 1);
    bus0.core_req = '0; bus0.core_done = 4'b0001;
    tick();
    bus0.core_done = '0;
    check("C.fin",   32'(bus0.finished), 1);
    check("C.kill0", 32'(bus0.kill), 0);
    check("C.found", 32'(bus0.found), 0);

    // Reset in DRAIN with kill high, then a clean search.
    bus0.core_req = 4'hf; bus0.start = 1;
    tick();
    bus0.start = 0;
    tick();
    check("D.grant1", 32'(bus0.core_grant), 32'(4'b0010));
    bus0.abort = 1;
    tick();
    bus0.abort = 0;
    check("D.kill", 32'(bus0.kill), 1);
    #2;
    reset = 1'b0;
    #1;
    check("D.rst.kill",  32'(bus0.kill), 0);
    check("D.rst.busy",  32'(bus0.busy), 0);
    check("D.rst.grant", 32'(bus0.core_grant), 0);
    check("D.rst.base",  32'(bus0.core_base), 0);
    check("D.rst.end",   32'(bus0.core_end), 0);
    check("D.rst.fkey",  32'(bus0.found_key), 0);
    check("D.rst.fin",   32'(bus0.finished), 0);
    check("D.rst.found", 32'(bus0.found), 0);
    reset = 1'b1;
    repeat (4) tick();
    bus0.core_req = 4'hf; bus0.start = 1;
    tick();
    bus0.start = 0;
    check("D.clean.busy", 32'(bus0.busy), 1);
    tick();
    chk_chunk("D.clean.c0", bus0.core_grant, 4'b0001, bus0.core_base, 24'd0, bus0.core_end, 24'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rc4_key_dispatch.md
RC4_KEY_DISPATCH -- requirements
Module: rc4_key_dispatch

Interface
REQ-001 Parameter NUM_CORES, default 4: number of decryption cores served (1..16).
REQ-002 Parameter KEY_BITS, default 24: key width in bits.
REQ-003 Parameter CHUNK_LOG, default 10: log2 of the number of keys per dispatched chunk.
REQ-004 Parameter KEY_LOWER, default 0: first key of the search space.
REQ-005 Parameter KEY_UPPER, default 24'hffffff: last key of the search space, inclusive.
REQ-006 clk  in  1  single system clock; all logic is on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle pulse that begins a search.
REQ-009 abort  in  1  one-cycle pulse that terminates a search.
REQ-010 core_req  in  NUM_CORES  level; core i is idle and wants a chunk.
REQ-011 core_done  in  NUM_CORES  one-cycle pulse; core i finished its chunk.
REQ-012 core_hit  in  NUM_CORES  qualified by core_done[i]; core i found a valid key.
REQ-013 core_hit_key  in  NUM_CORES x KEY_BITS  qualified by core_done[i]; the successful key.
REQ-014 core_grant  out  NUM_CORES  one-hot or zero; chunk assigned this cycle.
REQ-015 core_base  out  KEY_BITS  first key of the granted chunk; valid when core_grant is nonzero.
REQ-016 core_end  out  KEY_BITS  last key of the granted chunk, inclusive; valid with core_base.
REQ-017 kill  out  1  level; all cores abandon work.
REQ-018 busy, finished, found  out  1 each  status flags.
REQ-019 found_key  out  KEY_BITS  winning key; valid while found=1.

Function
REQ-020 FSM states: IDLE, DISPATCH, DRAIN, DONE.
- IDLE --start--> DISPATCH: next_base loaded with KEY_LOWER; outstanding mask cleared.
REQ-021 DISPATCH: at most one grant per cycle.
- Grant goes round-robin among cores with core_req=1 and outstanding=0, starting after the last core granted.
- A grant sets that core's outstanding bit.
- core_end = min(next_base + 2^CHUNK_LOG - 1, KEY_UPPER).
- next_base advances to core_end + 1, computed at KEY_BITS+1 width.
REQ-022 Space exhausted (core_end == KEY_UPPER at a grant): no further grants; DISPATCH -> DRAIN with kill=0.
REQ-023 core_done[i] clears outstanding[i].
- Same-cycle core_done[i] and core_req[i]: core i is not eligible until the following cycle.
REQ-024 First hit in time wins.
- On core_done[i] with core_hit[i] in DISPATCH or DRAIN (kill=0): latch found_key and set found; state -> DRAIN with kill=1.
- Simultaneous hits: the lowest index wins.
- Hits while kill=1 are ignored.
REQ-025 abort in DISPATCH or DRAIN -> DRAIN with kill=1; found is unchanged.
REQ-026 DRAIN -> DONE when the outstanding mask is zero, counting core_done in the same cycle; kill deasserts on entry to DONE.
REQ-027 DONE: finished=1 held; start -> DISPATCH.
- start reinitialises as in REQ-020 and clears found.
REQ-028 start in DISPATCH or DRAIN is ignored; abort in IDLE or DONE is ignored.
REQ-029 busy=1 in DISPATCH and DRAIN, 0 otherwise.
REQ-030 No grant is issued in DRAIN, DONE or IDLE.
REQ-031 core_grant, kill, busy, finished and found are registered outputs.

Reset
REQ-032 reset low asynchronously forces the following, mid-search or not:
- state = IDLE
- core_grant = 0, kill = 0, busy = 0, finished = 0, found = 0
- found_key = 0, core_base = 0, core_end = 0
- outstanding mask = 0, round-robin pointer = core 0
REQ-033 Reset release is synchronised so that state leaves reset on a clock edge.

Structure
REQ-034 Package rc4_pkg holds the FSM state enum, key_t (KEY_BITS-wide logic) and the default KEY_BITS and CHUNK_LOG constants.
REQ-035 Round-robin arbitration is a sub-module rr_arbiter, parameterised by NUM_CORES, with request in, one-hot grant out and an advance enable.

Verification
REQ-036 NUM_CORES=4, CHUNK_LOG=2, KEY_LOWER=0, KEY_UPPER=15, all cores requesting -> grants to cores 0,1,2,3 on consecutive cycles with base/end 0/3, 4/7, 8/11, 12/15, then DRAIN.
REQ-037 Same setup with no hits; all four core_done pulses -> DONE, finished=1, found=0, kill never asserted.
REQ-038 Cores 1 and 3 report hits in the same cycle with keys 5 and 13 -> found_key=5, kill=1 until the remaining outstanding cores report done.
REQ-039 KEY_UPPER=9, CHUNK_LOG=2 -> chunks 0/3, 4/7, 8/9, with no grant past 9.
- KEY_UPPER=24'hffffff with final chunk base 24'hfffc00 -> no wrap to 0.
REQ-040 abort issued 2 cycles after start -> kill=1 and grants stop immediately; DONE once outstanding cores finish, found=0.
REQ-041 reset asserted while in DRAIN with kill=1 -> all outputs 0 within the same cycle; a later start runs a clean search.
